// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and the memory (slave).
interface pc_fetch_unit_if;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;

  modport master (
    output instr_address,
    output instr_read,
    input  instr_waitrequest,
    input  instr_readdata
  );

  modport slave (
    input  instr_address,
    input  instr_read,
    output instr_waitrequest,
    output instr_readdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / instruction fetch stage with MIPS delay-slot semantics and halt-on-HALT_ADDR.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned taken target traps via addr_fault).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  pc_fetch_unit_if.master   mem,
  input  logic [1:0]        pc_sel,
  input  logic              is_true,
  input  logic [31:0]       rs_data,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [31:0]       pc_out,
  output logic [31:0]       link_addr,
  output logic              active,
  output logic              addr_fault
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] link_q, link_d;
  logic        pending_q, pending_d;
  logic        read_q, read_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] taken_s;
  logic [31:0] target_new_s;
  logic [31:0] nxt_s;
  logic        take_s;
  logic        fault_hit_s;

  // Branch/jump target and next-PC for the instruction currently in EXEC.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    case (pc_sel)
      2'b01:   taken_s = pc_plus4_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      2'b10:   taken_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
      2'b11:   taken_s = rs_data;
      default: taken_s = pc_plus4_s;
    endcase
    // A delay slot never starts a second transfer.
    take_s = !pending_q && ((pc_sel == 2'b01 && is_true) || pc_sel[1]);
`ifdef PC_ALIGN_CHECK_EN
    target_new_s = taken_s;
    fault_hit_s  = take_s && (taken_s[1:0] != 2'b00);
`else
    target_new_s = {taken_s[31:2], 2'b00};
    fault_hit_s  = 1'b0;
`endif
    if (pending_q) begin
      nxt_s = target_q;
    end else begin
      nxt_s = pc_plus4_s;
    end
  end

  // Next-state and next-output computation for the FETCH/EXEC/HALTED machine.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    instr_d   = instr_q;
    link_d    = link_q;
    pending_d = pending_q;
    read_d    = read_q;
    valid_d   = valid_q;
    active_d  = active_q;
    fault_d   = fault_q;
    if (clk_enable) begin
      case (state_q)
        S_FETCH: begin
          if (!mem.instr_waitrequest) begin
            instr_d = mem.instr_readdata;
            state_d = S_EXEC;
            read_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            read_d  = 1'b1;
          end
        end
        S_EXEC: begin
          valid_d = 1'b0;
          if (fault_hit_s) begin
            fault_d  = 1'b1;
            state_d  = S_HALTED;
            read_d   = 1'b0;
            active_d = 1'b0;
          end else begin
            pc_d      = nxt_s;
            link_d    = nxt_s + 32'd8;
            pending_d = take_s;
            if (take_s) begin
              target_d = target_new_s;
            end else begin
              target_d = target_q;
            end
            if (nxt_s == HALT_ADDR) begin
              state_d  = S_HALTED;
              read_d   = 1'b0;
              active_d = 1'b0;
            end else begin
              state_d  = S_FETCH;
              read_d   = 1'b1;
            end
          end
        end
        S_HALTED: begin
          read_d   = 1'b0;
          valid_d  = 1'b0;
          active_d = 1'b0;
        end
        default: begin
          state_d  = S_HALTED;
          read_d   = 1'b0;
          valid_d  = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs; reset abandons any stalled fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      target_q  <= 32'd0;
      instr_q   <= 32'd0;
      link_q    <= RESET_VECTOR + 32'd8;
      pending_q <= 1'b0;
      read_q    <= 1'b1;
      valid_q   <= 1'b0;
      active_q  <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      instr_q   <= instr_d;
      link_q    <= link_d;
      pending_q <= pending_d;
      read_q    <= read_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      fault_q   <= fault_d;
    end
  end

  assign mem.instr_address = pc_q;
  assign mem.instr_read    = read_q;
  assign instr_out         = instr_q;
  assign instr_valid       = valid_q;
  assign pc_out            = pc_q;
  assign link_addr         = link_q;
  assign active            = active_q;
`ifdef PC_ALIGN_CHECK_EN
  assign addr_fault        = fault_q;
`else
  assign addr_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch/exec rules.
module tb_pc_fetch_unit;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  pc_sel;
  logic        is_true;
  logic [31:0] rs_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        active;
  logic        addr_fault;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .mem        (bus.master),
    .pc_sel     (pc_sel),
    .is_true    (is_true),
    .rs_data    (rs_data),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .link_addr  (link_addr),
    .active     (active),
    .addr_fault (addr_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 = waiting for a word, 1 = executing, 2 = halted
  int          m_phase = 0;
  logic [31:0] m_pc = 32'd0, m_tgt = 32'd0, m_instr = 32'd0;
  logic        m_pend = 1'b0, m_fault = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt, t, p4;
    int off;
    bit trap;
    if (reset) begin
      m_phase = 0; m_pc = RV; m_pend = 1'b0; m_instr = 32'd0; m_fault = 1'b0;
    end else if (clk_enable) begin
      if (m_phase == 0) begin
        if (!bus.instr_waitrequest) begin
          m_instr = bus.instr_readdata;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        trap = 1'b0;
        p4 = m_pc + 32'd4;
        nxt = p4;
        if (m_pend) begin
          nxt = m_tgt;
          m_pend = 1'b0;
        end else if (pc_sel != 2'd0 && !(pc_sel == 2'd1 && !is_true)) begin
          if (pc_sel == 2'd1) begin
            off = $signed(m_instr[15:0]);
            t = p4 + 32'(off * 4);
          end else if (pc_sel == 2'd2) begin
            t = (p4 & 32'hF0000000) | ((m_instr & 32'h03FFFFFF) << 2);
          end else begin
            t = rs_data;
          end
`ifdef PC_ALIGN_CHECK_EN
          if (t % 32'd4 != 32'd0) trap = 1'b1;
`else
          t = t - (t % 32'd4);
`endif
          m_pend = 1'b1;
          m_tgt = t;
        end
        if (trap) begin
          m_fault = 1'b1;
          m_pend = 1'b0;
          m_phase = 2;
        end else begin
          m_pc = nxt;
          m_phase = (nxt == 32'd0) ? 2 : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("instr_read", {31'd0, bus.instr_read}, {31'd0, m_phase == 0});
    chk("instr_address", bus.instr_address, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 1});
    chk("active", {31'd0, active}, {31'd0, m_phase != 2});
    chk("instr_out", instr_out, m_instr);
    chk("pc_out", pc_out, m_pc);
    chk("link_addr", link_addr, m_pc + 32'd8);
    chk("addr_fault", {31'd0, addr_fault}, {31'd0, m_fault});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b1; pc_sel = 2'd0; bus.instr_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic fetch_exec(input logic [31:0] word, input logic [1:0] sel,
                            input logic tr, input logic [31:0] rs);
    bus.instr_waitrequest = 1'b0; bus.instr_readdata = word; pc_sel = 2'd0;
    tick();
    pc_sel = sel; is_true = tr; rs_data = rs;
    tick();
    pc_sel = 2'd0; is_true = 1'b0;
  endtask

  initial begin
    int halted_cycles;
    reset = 1'b1; clk_enable = 1'b1; pc_sel = 2'd0; is_true = 1'b0; rs_data = 32'd0;
    bus.instr_waitrequest = 1'b0; bus.instr_readdata = 32'd0;

    // reset, straight-line fetch
    do_reset();
    chk("t1 reset addr", bus.instr_address, 32'hBFC00000);
    chk("t1 reset read", {31'd0, bus.instr_read}, 32'd1);
    bus.instr_readdata = 32'h24010001;
    tick();
    chk("t1 link", link_addr, 32'hBFC00008);
    chk("t1 valid", {31'd0, instr_valid}, 32'd1);
    tick();
    chk("t1 next fetch", bus.instr_address, 32'hBFC00004);

    // waitrequest stall
    bus.instr_waitrequest = 1'b1; bus.instr_readdata = 32'h12345678;
    repeat (3) tick();
    chk("t2 held addr", bus.instr_address, 32'hBFC00004);
    chk("t2 held instr", instr_out, 32'h24010001);
    bus.instr_waitrequest = 1'b0;
    tick();
    chk("t2 instr", instr_out, 32'h12345678);
    chk("t2 valid", {31'd0, instr_valid}, 32'd1);
    tick();

    // BEQ taken / not taken
    do_reset();
    fetch_exec(32'h10000003, 2'b01, 1'b1, 32'd0);
    chk("t3 slot", bus.instr_address, 32'hBFC00004);
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("t3 taken", bus.instr_address, 32'hBFC00010);
    do_reset();
    fetch_exec(32'h10000003, 2'b01, 1'b0, 32'd0);
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("t3 not taken", bus.instr_address, 32'hBFC00008);

    // JR to 0 halts after the delay slot
    do_reset();
    fetch_exec(32'd0, 2'b11, 1'b0, 32'hBFC00020);
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("t4 at 20", bus.instr_address, 32'hBFC00020);
    fetch_exec(32'd0, 2'b11, 1'b0, 32'd0);
    chk("t4 slot addr", bus.instr_address, 32'hBFC00024);
    tick();
    chk("t4 slot valid", {31'd0, instr_valid}, 32'd1);
    tick();
    repeat (4) tick();
    chk("t4 halted", {31'd0, active}, 32'd0);
    chk("t4 no read", {31'd0, bus.instr_read}, 32'd0);
    do_reset();
    chk("t4 restart", bus.instr_address, 32'hBFC00000);

    // clk_enable freeze in FETCH and EXEC; J in a delay slot is ignored
    clk_enable = 1'b0; bus.instr_readdata = 32'h10000003;
    repeat (5) tick();
    chk("t5 frozen fetch", bus.instr_address, 32'hBFC00000);
    clk_enable = 1'b1;
    tick();
    clk_enable = 1'b0; pc_sel = 2'b01; is_true = 1'b1;
    repeat (5) tick();
    chk("t5 frozen exec", {31'd0, instr_valid}, 32'd1);
    clk_enable = 1'b1;
    tick();
    fetch_exec(32'h08000040, 2'b10, 1'b0, 32'd0);
    chk("t5 J ignored", bus.instr_address, 32'hBFC00010);

    // misaligned JR target
    do_reset();
    fetch_exec(32'd0, 2'b11, 1'b0, 32'h00400002);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6 fault", {31'd0, addr_fault}, 32'd1);
    chk("t6 inactive", {31'd0, active}, 32'd0);
`else
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("t6 aligned", bus.instr_address, 32'h00400000);
    chk("t6 no fault", {31'd0, addr_fault}, 32'd0);
`endif

    // wrap from FFFFFFFC to 0 halts
    do_reset();
    fetch_exec(32'd0, 2'b11, 1'b0, 32'hFFFFFFFC);
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("wrap top", bus.instr_address, 32'hFFFFFFFC);
    fetch_exec(32'd0, 2'b00, 1'b0, 32'd0);
    chk("wrap halt addr", bus.instr_address, 32'd0);
    chk("wrap halted", {31'd0, active}, 32'd0);

    // randomized traffic
    do_reset();
    halted_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      halted_cycles = (m_phase == 2) ? halted_cycles + 1 : 0;
      reset = ($urandom_range(0, 399) == 0) || (halted_cycles > 6);
      clk_enable = ($urandom_range(0, 7) != 0);
      bus.instr_waitrequest = ($urandom_range(0, 2) == 0);
      bus.instr_readdata = $urandom;
      pc_sel = 2'($urandom_range(0, 3));
      is_true = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
        0:       rs_data = 32'd0;
        1, 2:    rs_data = $urandom;
        default: rs_data = $urandom & 32'hFFFFFFFC;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
